// File: rtl/factorial_pkg.sv
// Shared select encodings for the factorial controller and datapath.
package factorial_pkg;

  // Default operand / product widths.
  localparam int N_W_DEF = 8;
  localparam int R_W_DEF = 32;

  // A-register select driven by the controller.
  typedef enum logic [1:0] {
    WA_HOLD = 2'b00,
    WA_DEC  = 2'b01,
    WA_LOAD = 2'b10,
    WA_ILL  = 2'b11   // never issued by a correct controller; treated as hold
  } wa_e;

  // B-register select driven by the controller.
  typedef enum logic [1:0] {
    WB_INIT = 2'b00,
    WB_MUL  = 2'b01,
    WB_HOLD = 2'b10,
    WB_ILL  = 2'b11   // never issued by a correct controller; treated as hold
  } wb_e;

  // Multiplier operand taken from A: zero is promoted to one so the
  // terminating iterate cycle (A already 0) leaves the product unchanged.
  function automatic logic [N_W_DEF-1:0] mul_operand(input logic [N_W_DEF-1:0] a);
    return (a == '0) ? N_W_DEF'(1) : a;
  endfunction

endpackage

// File: rtl/factorial_datapath_if.sv
// Controller <-> datapath bundle: selects and operand in, flag and result out.
interface factorial_datapath_if
  import factorial_pkg::*;
#(
  parameter int N_W = 8,
  parameter int R_W = 32
);

  logic [N_W-1:0] n;
  wa_e            wa;
  wb_e            wb;
  logic           z_out;
  logic [R_W-1:0] result;
  logic           ovf;

  // Controller side: issues selects and operand, watches flag and result.
  modport master (
    output n,
    output wa,
    output wb,
    input  z_out,
    input  result,
    input  ovf
  );

  // Datapath side.
  modport slave (
    input  n,
    input  wa,
    input  wb,
    output z_out,
    output result,
    output ovf
  );

endinterface

// File: rtl/factorial_mul_ovf.sv
// Combinational R_W x N_W shift-and-add multiplier. Returns the low R_W
// product bits and flags any nonzero bit in the upper N_W bits.
module factorial_mul_ovf #(
  parameter int N_W = 8,
  parameter int R_W = 32
) (
  input  logic [R_W-1:0] b_i,
  input  logic [N_W-1:0] m_i,
  output logic [R_W-1:0] prod_o,
  output logic           ovf_o
);

  localparam int P_W = R_W + N_W;

  logic [P_W-1:0] pp [N_W];
  logic [P_W-1:0] full_prod;

  // One partial product per multiplier bit, pre-shifted into place.
  generate
    for (genvar gi = 0; gi < N_W; gi++) begin : g_pp
      assign pp[gi] = m_i[gi] ? ({{N_W{1'b0}}, b_i} << gi) : '0;
    end
  endgenerate

  // Sum the partial products into the full-width product.
  always_comb begin
    full_prod = '0;
    for (int i = 0; i < N_W; i++) begin
      full_prod = full_prod + pp[i];
    end
  end

  assign prod_o = full_prod[R_W-1:0];
  assign ovf_o  = |full_prod[P_W-1:R_W];

endmodule

// File: rtl/factorial_datapath.sv
// Factorial datapath: down-counter A, running product B and a sticky
// overflow flag, all steered by the controller's wa/wb selects.
module factorial_datapath
  import factorial_pkg::*;
#(
  parameter int N_W = 8,
  parameter int R_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  factorial_datapath_if.slave  bus
);

  logic [N_W-1:0] a_q, a_d;
  logic [R_W-1:0] b_q, b_d;
  logic           ovf_q, ovf_d;

  logic [N_W-1:0] mul_m;
  logic [R_W-1:0] mul_prod;
  logic           mul_ovf;

  // A==0 multiplies by one so the closing iterate cycle is a no-op on B.
  assign mul_m = (a_q == '0) ? N_W'(1) : a_q;

  factorial_mul_ovf #(
    .N_W (N_W),
    .R_W (R_W)
  ) u_mul (
    .b_i    (b_q),
    .m_i    (mul_m),
    .prod_o (mul_prod),
    .ovf_o  (mul_ovf)
  );

  // A next state: load, saturating decrement, or hold (incl. illegal code).
  always_comb begin
    a_d = a_q;
    case (bus.wa)
      WA_LOAD: a_d = bus.n;
      WA_DEC:  if (a_q != '0) a_d = a_q - N_W'(1);
      default: a_d = a_q;
    endcase
  end

  // B / ovf next state: init clears ovf, multiply makes ovf sticky.
  always_comb begin
    b_d   = b_q;
    ovf_d = ovf_q;
    case (bus.wb)
      WB_INIT: begin
        b_d   = R_W'(1);
        ovf_d = 1'b0;
      end
      WB_MUL: begin
        b_d   = mul_prod;
        ovf_d = ovf_q | mul_ovf;
      end
      default: begin
        b_d   = b_q;
        ovf_d = ovf_q;
      end
    endcase
  end

  // Register update; low rst clears everything regardless of selects.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      ovf_q <= ovf_d;
    end
  end

  // Terminate flag depends on A only, never on the selects.
  assign bus.z_out  = (a_q <= N_W'(1));
  assign bus.result = b_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_factorial_datapath.sv
// Self-checking bench for factorial_datapath with a factorial reference model.
module tb_factorial_datapath;
  import factorial_pkg::*;

  localparam int N_W = 8;
  localparam int R_W = 32;
  localparam int MAX_EDGES = 300;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  factorial_datapath_if #(.N_W(N_W), .R_W(R_W)) bus ();

  factorial_datapath #(.N_W(N_W), .R_W(R_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input wa_e wa, input wb_e wb, input int n);
    bus.wa = wa;
    bus.wb = wb;
    bus.n  = N_W'(n);
  endtask

  // n! truncated to R_W bits; o set if any partial product ever exceeds R_W bits.
  function automatic void fact_model(input int n, output logic [R_W-1:0] r, output logic o);
    longint unsigned b;
    longint unsigned p;
    b = 1;
    o = 1'b0;
    for (int k = n; k >= 2; k--) begin
      p = b * longint'(k);
      if ((p >> R_W) != 0) o = 1'b1;
      b = p & ((64'd1 << R_W) - 1);
    end
    r = b[R_W-1:0];
  endfunction

  // Controller-like run: LOAD/INIT, DEC/MUL until z_out, one more DEC/MUL, then HOLD.
  task automatic run_fact(input int n, output int edges);
    drive(WA_LOAD, WB_INIT, n);
    tick();
    edges = 1;
    while (bus.z_out !== 1'b1 && edges < MAX_EDGES) begin
      drive(WA_DEC, WB_MUL, 0);
      tick();
      edges++;
    end
    n_checks++;
    if (edges >= MAX_EDGES) begin
      n_fail++;
      $display("FAIL run_budget n=%0d: z_out never rose within %0d edges", n, MAX_EDGES);
    end
    drive(WA_DEC, WB_MUL, 0);
    tick();
    edges++;
    drive(WA_HOLD, WB_HOLD, 0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(wa_e'($urandom_range(0, 3)), wb_e'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      tick();
    end
    n_checks++;
    if (bus.result !== '0) begin n_fail++; $display("FAIL reset_result got=%0d exp=0", bus.result); end
    n_checks++;
    if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
    n_checks++;
    if (bus.z_out !== 1'b1) begin n_fail++; $display("FAIL reset_z got=%b exp=1", bus.z_out); end
    rst = 1'b1;
    drive(WA_HOLD, WB_HOLD, 9);
    tick();
    tick();
    n_checks++;
    if (bus.result !== '0 || bus.ovf !== 1'b0 || bus.z_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hold got result=%0d ovf=%b z=%b exp 0/0/1", bus.result, bus.ovf, bus.z_out);
    end
    $display("reset: result=%0d ovf=%b z_out=%b", bus.result, bus.ovf, bus.z_out);
  endtask

  task automatic test_n5();
    int a_exp;
    logic [R_W-1:0] b_exp;
    drive(WA_LOAD, WB_INIT, 5);
    tick();
    a_exp = 5;
    b_exp = 1;
    for (int step = 0; step < 6; step++) begin
      n_checks++;
      if (bus.result !== b_exp || bus.z_out !== (a_exp <= 1)) begin
        n_fail++;
        $display("FAIL n5_trace step=%0d got result=%0d z=%b exp result=%0d z=%b",
                 step, bus.result, bus.z_out, b_exp, (a_exp <= 1));
      end
      $display("n5 step=%0d result=%0d z_out=%b", step, bus.result, bus.z_out);
      if (step < 5) begin
        drive(WA_DEC, WB_MUL, 0);
        tick();
        b_exp = b_exp * R_W'((a_exp == 0) ? 1 : a_exp);
        if (a_exp > 0) a_exp--;
      end
    end
    drive(WA_HOLD, WB_HOLD, 77);
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (bus.result !== 32'd120 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL n5_done got result=%0d ovf=%b exp 120/0", bus.result, bus.ovf);
    end
  endtask

  task automatic test_small();
    for (int n = 0; n < 2; n++) begin
      drive(WA_LOAD, WB_INIT, n);
      tick();
      n_checks++;
      if (bus.z_out !== 1'b1 || bus.result !== 32'd1) begin
        n_fail++;
        $display("FAIL small_load n=%0d got z=%b result=%0d exp 1/1", n, bus.z_out, bus.result);
      end
      drive(WA_DEC, WB_MUL, 0);
      tick();
      n_checks++;
      if (bus.z_out !== 1'b1 || bus.result !== 32'd1 || bus.ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL small_mul n=%0d got z=%b result=%0d ovf=%b exp 1/1/0", n, bus.z_out, bus.result, bus.ovf);
      end
      $display("small n=%0d result=%0d", n, bus.result);
      drive(WA_HOLD, WB_HOLD, 0);
      tick();
    end
  endtask

  task automatic test_overflow();
    int edges;
    run_fact(12, edges);
    n_checks++;
    if (bus.result !== 32'd479001600 || bus.ovf !== 1'b0 || edges != 13) begin
      n_fail++;
      $display("FAIL ovf_n12 got result=%0d ovf=%b edges=%0d exp 479001600/0/13", bus.result, bus.ovf, edges);
    end
    $display("ovf n=12 result=%0d ovf=%b", bus.result, bus.ovf);
    run_fact(13, edges);
    n_checks++;
    if (bus.result !== 32'd1932053504 || bus.ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_n13 got result=%0d ovf=%b exp 1932053504/1", bus.result, bus.ovf);
    end
    $display("ovf n=13 result=%0d ovf=%b", bus.result, bus.ovf);
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", bus.ovf); end
    drive(WA_LOAD, WB_INIT, 3);
    tick();
    n_checks++;
    if (bus.ovf !== 1'b0 || bus.result !== 32'd1) begin
      n_fail++;
      $display("FAIL ovf_init_clear got ovf=%b result=%0d exp 0/1", bus.ovf, bus.result);
    end
    drive(WA_HOLD, WB_HOLD, 0);
    tick();
  endtask

  task automatic test_illegal();
    int edges;
    drive(WA_LOAD, WB_INIT, 6);
    tick();
    drive(WA_DEC, WB_MUL, 0);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(WA_ILL, WB_ILL, 200);
      tick();
      n_checks++;
      if (bus.result !== 32'd30 || bus.z_out !== 1'b0 || bus.ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_hold cyc=%0d got result=%0d z=%b ovf=%b exp 30/0/0",
                 i, bus.result, bus.z_out, bus.ovf);
      end
    end
    edges = 0;
    while (bus.z_out !== 1'b1 && edges < MAX_EDGES) begin
      drive(WA_DEC, WB_MUL, 0);
      tick();
      edges++;
    end
    drive(WA_DEC, WB_MUL, 0);
    tick();
    drive(WA_HOLD, WB_HOLD, 0);
    n_checks++;
    if (bus.result !== 32'd720 || edges != 3) begin
      n_fail++;
      $display("FAIL illegal_resume got result=%0d iters=%0d exp 720/3", bus.result, edges);
    end
    $display("illegal resume result=%0d", bus.result);
  endtask

  task automatic test_reset_mid();
    int edges;
    run_fact(13, edges);
    rst = 1'b0;
    drive(WA_HOLD, WB_HOLD, 0);
    tick();
    rst = 1'b1;
    n_checks++;
    if (bus.ovf !== 1'b0 || bus.result !== '0) begin
      n_fail++;
      $display("FAIL reset_clears_ovf got ovf=%b result=%0d exp 0/0", bus.ovf, bus.result);
    end
    drive(WA_LOAD, WB_INIT, 7);
    tick();
    drive(WA_DEC, WB_MUL, 0);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_checks++;
    if (bus.result !== '0 || bus.ovf !== 1'b0 || bus.z_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid got result=%0d ovf=%b z=%b exp 0/0/1", bus.result, bus.ovf, bus.z_out);
    end
    run_fact(4, edges);
    n_checks++;
    if (bus.result !== 32'd24 || edges != 5) begin
      n_fail++;
      $display("FAIL reset_restart got result=%0d edges=%0d exp 24/5", bus.result, edges);
    end
    $display("reset mid-run restart n=4 result=%0d", bus.result);
  endtask

  task automatic test_random();
    int n;
    int edges;
    logic [R_W-1:0] r_exp;
    logic o_exp;
    for (int t = 0; t < 20; t++) begin
      n = int'($urandom_range(0, 40));
      fact_model(n, r_exp, o_exp);
      run_fact(n, edges);
      n_checks++;
      if (bus.result !== r_exp || bus.ovf !== o_exp || edges != ((n < 2) ? 2 : n + 1)) begin
        n_fail++;
        $display("FAIL random n=%0d got result=%0d ovf=%b edges=%0d exp result=%0d ovf=%b edges=%0d",
                 n, bus.result, bus.ovf, edges, r_exp, o_exp, (n < 2) ? 2 : n + 1);
      end
      $display("random n=%0d result=%0d ovf=%b edges=%0d", n, bus.result, bus.ovf, edges);
      for (int h = 0; h < int'($urandom_range(0, 2)); h++) tick();
    end
  endtask

  initial begin
    drive(WA_HOLD, WB_HOLD, 0);
    test_reset();
    test_n5();
    test_small();
    test_overflow();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
